// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register file dump reader.
//   rf_dump_state_e : dump controller states
//   RF_READ_LAT     : register file debug read latency in cycles (1..4)
//   rf_dump_beat_t  : one (index, value) beat. The fields are wide enough for
//                     any AW <= 16 and XLEN <= 64, so monitors can log beats
//                     from any configuration.
package rf_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ADDR,
        WAIT,
        SEND,
        DONE
    } rf_dump_state_e;

    localparam int RF_READ_LAT = 1;

    typedef struct packed {
        logic [15:0] idx;
        logic [63:0] data;
    } rf_dump_beat_t;

endpackage

// File: rtl/rf_dump_out_reg.sv
// rf_dump_out_reg: valid/ready output holding register for one dump beat.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : capture load_idx/load_data and raise valid
//   clear      : drop valid and zero the held beat (has priority over load)
//   load_idx   : index to capture
//   load_data  : value to capture
//   ready      : consumer accepts the beat; valid falls after valid && ready
//   valid      : beat valid
//   idx, data  : held beat, stable while valid is high and not yet accepted
module rf_dump_out_reg #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [AW-1:0]   load_idx,
    input  logic [XLEN-1:0] load_data,
    input  logic            ready,
    output logic            valid,
    output logic [AW-1:0]   idx,
    output logic [XLEN-1:0] data
);

    logic            valid_reg, valid_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic [XLEN-1:0] data_reg, data_next;

    always_comb begin
        valid_next = valid_reg;
        idx_next   = idx_reg;
        if (clear) begin
            valid_next = 1'b0;
            idx_next   = '0;
        end else if (load) begin
            valid_next = 1'b1;
            idx_next   = load_idx;
        end else if (valid_reg && ready) begin
            valid_next = 1'b0;
        end
    end

    // Data only changes on load or clear; acceptance leaves the value in place.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_data
            assign data_next[gi] = clear ? 1'b0 : (load ? load_data[gi] : data_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            idx_reg   <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
        end
    end

    assign valid = valid_reg;
    assign idx   = idx_reg;
    assign data  = data_reg;

endmodule

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: debug reader that freezes the core and streams register
// file contents [START_IDX..END_IDX] as (index, value) beats over valid/ready.
//   clk, rst      : clock, asynchronous active-low reset
//   en_i          : external run enable for the core
//   start_i       : dump request, only looked at while idle
//   core_en_o     : en_i gated off while a dump is in progress (and in reset)
//   rf_addr_o     : register file debug read index
//   rf_data_i     : register file read data, RF_READ_LAT cycles after rf_addr_o
//   dump_valid_o  : beat valid, independent of dump_ready_i
//   dump_ready_i  : consumer accepts beat
//   dump_idx_o    : index of current beat
//   dump_data_o   : value of current beat
//   busy_o        : dump in progress (HALT through DONE)
//   done_o        : one-cycle pulse after the last beat is accepted
//   csum_o        : only with RF_DUMP_CSUM_EN defined; running XOR of all
//                   accepted beat values of the current/last dump
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int START_IDX = 1,
    parameter int END_IDX   = 31
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            start_i,
    output logic            core_en_o,
    output logic [AW-1:0]   rf_addr_o,
    input  logic [XLEN-1:0] rf_data_i,
    output logic            dump_valid_o,
    input  logic            dump_ready_i,
    output logic [AW-1:0]   dump_idx_o,
    output logic [XLEN-1:0] dump_data_o,
    output logic            busy_o,
    output logic            done_o
`ifdef RF_DUMP_CSUM_EN
    ,
    output logic [XLEN-1:0] csum_o
`endif
);

    localparam logic [AW-1:0] FIRST_IDX = AW'(START_IDX);
    localparam logic [AW-1:0] LAST_IDX  = AW'(END_IDX);
    localparam logic [1:0]    LAT_INIT  = 2'(RF_READ_LAT - 1);

    rf_dump_state_e  state_reg, state_next;
    logic [AW-1:0]   idx_reg, idx_next;
    logic [AW-1:0]   rf_addr_reg, rf_addr_next;
    logic [1:0]      lat_reg, lat_next;
    logic            load, clear;
    logic            accept;

    assign accept = (state_reg == SEND) && dump_valid_o && dump_ready_i;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        rf_addr_next = rf_addr_reg;
        lat_next     = lat_reg;
        load         = 1'b0;
        clear        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                // Core is already gated; this cycle lets the last write-back land.
                rf_addr_next = idx_reg;
                state_next   = ADDR;
            end
            ADDR: begin
                lat_next   = LAT_INIT;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_reg == 2'd0) begin
                    load       = 1'b1;
                    state_next = SEND;
                end else begin
                    lat_next = lat_reg - 2'd1;
                end
            end
            SEND: begin
                if (accept) begin
                    // Compare before incrementing so END_IDX = 2**AW-1 never wraps.
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next     = idx_reg + AW'(1);
                        rf_addr_next = idx_reg + AW'(1);
                        state_next   = ADDR;
                    end
                end
            end
            DONE: begin
                clear      = 1'b1;
                idx_next   = FIRST_IDX;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            idx_reg     <= FIRST_IDX;
            rf_addr_reg <= '0;
            lat_reg     <= 2'd0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            rf_addr_reg <= rf_addr_next;
            lat_reg     <= lat_next;
        end
    end

    rf_dump_out_reg #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .clear     (clear),
        .load_idx  (idx_reg),
        .load_data (rf_data_i),
        .ready     (dump_ready_i),
        .valid     (dump_valid_o),
        .idx       (dump_idx_o),
        .data      (dump_data_o)
    );

    assign rf_addr_o = rf_addr_reg;
    assign busy_o    = (state_reg != IDLE);
    assign done_o    = (state_reg == DONE);
    // rst term forces the core off for the whole time reset is held.
    assign core_en_o = rst && en_i && !busy_o;

`ifdef RF_DUMP_CSUM_EN
    logic [XLEN-1:0] csum_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_reg <= '0;
        end else if ((state_reg == IDLE) && start_i) begin
            csum_reg <= '0;
        end else if (accept) begin
            csum_reg <= csum_reg ^ dump_data_o;
        end
    end

    assign csum_o = csum_reg;
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: randomized self-checking bench for rf_dump_reader.
// Two instances: the default range [1..31] and a single-register range [4..4].
// A registered-read register file model feeds both. Expected beats, done
// cycles and checksums come from the dump rules applied to the memory model.
// Build with RF_DUMP_CSUM_EN defined to also check csum_o.
module tb_rf_dump_reader;
    import rf_dump_pkg::*;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en_i = 1'b1;
    logic            start_i = 1'b0;
    logic            dump_ready_i = 1'b1;
    logic            core_en_o, dump_valid_o, busy_o, done_o;
    logic [AW-1:0]   rf_addr_o, dump_idx_o;
    logic [XLEN-1:0] dump_data_o;
    logic [XLEN-1:0] rf_data = '0;

    logic            start1 = 1'b0;
    logic            ready1 = 1'b1;
    logic            core_en1, valid1, busy1, done1;
    logic [AW-1:0]   rf_addr1, idx1;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] rf_data1 = '0;

`ifdef RF_DUMP_CSUM_EN
    logic [XLEN-1:0] csum_o, csum1;
`endif

    logic [XLEN-1:0] mem [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rf_data  <= mem[rf_addr_o];
        rf_data1 <= mem[rf_addr1];
    end

    rf_dump_reader dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .start_i      (start_i),
        .core_en_o    (core_en_o),
        .rf_addr_o    (rf_addr_o),
        .rf_data_i    (rf_data),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_idx_o   (dump_idx_o),
        .dump_data_o  (dump_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef RF_DUMP_CSUM_EN
        ,
        .csum_o       (csum_o)
`endif
    );

    rf_dump_reader #(
        .XLEN      (XLEN),
        .AW        (AW),
        .START_IDX (4),
        .END_IDX   (4)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .start_i      (start1),
        .core_en_o    (core_en1),
        .rf_addr_o    (rf_addr1),
        .rf_data_i    (rf_data1),
        .dump_valid_o (valid1),
        .dump_ready_i (ready1),
        .dump_idx_o   (idx1),
        .dump_data_o  (data1),
        .busy_o       (busy1),
        .done_o       (done1)
`ifdef RF_DUMP_CSUM_EN
        ,
        .csum_o       (csum1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rf_dump_beat_t   got_q[$];
    rf_dump_beat_t   exp_q[$];
    int              done_q[$];
    logic [XLEN-1:0] csum_at_done;
    logic [XLEN-1:0] exp_csum;
    logic            core_en_hist [512];
    int              hold_bad, stall_total;
    int              ready_mode, stall_idx, stall_len, stall_used, restart_at;
    logic            prev_valid, prev_rdy;
    logic [AW-1:0]   prev_idx;
    logic [XLEN-1:0] prev_data;

    // Reference: a dump of [s..e] is the ordered list of (i, mem[i]).
    function automatic void model_dump(input int s, input int e);
        exp_q.delete();
        exp_csum = '0;
        for (int i = s; i <= e; i++) begin
            exp_q.push_back('{idx: 16'(i), data: 64'(mem[i])});
            exp_csum = exp_csum ^ mem[i];
        end
    endfunction

    task automatic clear_log();
        got_q.delete();
        done_q.delete();
        hold_bad     = 0;
        stall_total  = 0;
        stall_used   = 0;
        prev_valid   = 1'b0;
        prev_rdy     = 1'b1;
        ready_mode   = 0;
        restart_at   = -1;
        csum_at_done = '0;
        for (int i = 0; i < 512; i++) core_en_hist[i] = 1'bx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Cycle 0 ends with the edge that samples start_i.
    task automatic pulse_start(input logic hold);
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = hold;
        cyc = 0;
    endtask

    // One cycle: sample DUT outputs at the falling edge, then drive ready.
    task automatic step();
        logic rdy;
        @(negedge clk);
        cyc++;
        rdy = 1'b1;
        if (ready_mode == 1) begin
            if (dump_valid_o && dump_idx_o == AW'(stall_idx) && stall_used < stall_len) begin
                rdy = 1'b0;
                stall_used++;
            end
        end else if (ready_mode == 2) begin
            rdy = ($urandom_range(0, 1) == 1);
        end
        dump_ready_i = rdy;
        if (restart_at > 0 && cyc == restart_at) start_i = 1'b1;
        if (restart_at > 0 && cyc == restart_at + 1) start_i = 1'b0;
        if (cyc < 512) core_en_hist[cyc] = core_en_o;
        if (prev_valid && !prev_rdy &&
            !(dump_valid_o && dump_idx_o == prev_idx && dump_data_o == prev_data)) hold_bad++;
        if (dump_valid_o && !rdy) stall_total++;
        if (dump_valid_o && rdy) begin
            got_q.push_back('{idx: 16'(dump_idx_o), data: 64'(dump_data_o)});
            $display("beat cyc=%0d idx=%0d data=%08h", cyc, dump_idx_o, dump_data_o);
        end
        if (done_o) begin
            done_q.push_back(cyc);
`ifdef RF_DUMP_CSUM_EN
            csum_at_done = csum_o;
`endif
        end
        prev_valid = dump_valid_o;
        prev_rdy   = rdy;
        prev_idx   = dump_idx_o;
        prev_data  = dump_data_o;
    endtask

    task automatic run_until(input int ndone, input int max_cyc);
        int n;
        n = 0;
        while (done_q.size() < ndone && n < max_cyc) begin
            step();
            n++;
        end
        step();
        step();
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_o, dump_valid_o, done_o, core_en_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy_o, dump_valid_o, done_o, core_en_o});
        end
        checks++;
        if ({rf_addr_o, dump_idx_o, dump_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%0d idx=%0d data=%0h expected 0", rf_addr_o, dump_idx_o, dump_data_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (core_en_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got core_en=%b busy=%b expected 1 0", core_en_o, busy_o);
        end
    endtask

    task automatic test_full_dump();
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
        model_dump(1, 31);
        clear_log();
        pulse_start(1'b0);
        run_until(1, 200);
        checks++;
        if (got_q.size() != 31) begin
            errors++;
            $display("FAIL full_count: got %0d expected 31", got_q.size());
        end
        for (int i = 0; i < 31 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_beat%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 95) begin
            errors++;
            $display("FAIL full_done: got count %0d first %0d expected 1 at 95", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        for (int c = 1; c <= 97; c++) begin
            checks++;
            if (core_en_hist[c] !== (c > 95)) begin
                errors++;
                $display("FAIL full_core_en cyc%0d: got %b expected %b", c, core_en_hist[c], (c > 95));
            end
        end
`ifdef RF_DUMP_CSUM_EN
        checks++;
        if (csum_at_done !== exp_csum) begin
            errors++;
            $display("FAIL full_csum: got %08h expected %08h", csum_at_done, exp_csum);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[4] = 32'h104;
        model_dump(1, 31);
        clear_log();
        ready_mode = 1;
        stall_idx  = 4;
        stall_len  = 5;
        pulse_start(1'b0);
        run_until(1, 250);
        checks++;
        if (got_q.size() != 31) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 31", got_q.size());
        end
        for (int i = 0; i < 31 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        checks++;
        if (hold_bad != 0 || stall_used != 5) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles, %0d stalls expected 0, 5", hold_bad, stall_used);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 100) begin
            errors++;
            $display("FAIL bp_done: got count %0d first %0d expected 1 at 100", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
    endtask

    task automatic test_random_ready();
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        model_dump(1, 31);
        clear_log();
        ready_mode = 2;
        pulse_start(1'b0);
        run_until(1, 400);
        checks++;
        if (got_q.size() != 31) begin
            errors++;
            $display("FAIL rnd_count: got %0d expected 31", got_q.size());
        end
        for (int i = 0; i < 31 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_beat%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].idx, got_q[i].data, exp_q[i].idx, exp_q[i].data);
            end
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL rnd_hold: got %0d unstable cycles expected 0", hold_bad);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 95 + stall_total) begin
            errors++;
            $display("FAIL rnd_done: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] : -1, 95 + stall_total);
        end
`ifdef RF_DUMP_CSUM_EN
        checks++;
        if (csum_at_done !== exp_csum) begin
            errors++;
            $display("FAIL rnd_csum: got %08h expected %08h", csum_at_done, exp_csum);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        do_reset();
        model_dump(1, 31);
        clear_log();
        restart_at = 20;
        pulse_start(1'b0);
        run_until(1, 200);
        repeat (5) step();
        checks++;
        if (got_q.size() != 31 || done_q.size() != 1) begin
            errors++;
            $display("FAIL busy_start: got %0d beats %0d done expected 31 1", got_q.size(), done_q.size());
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy %b expected 0", busy_o);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n;
        do_reset();
        model_dump(1, 31);
        clear_log();
        pulse_start(1'b0);
        n = 0;
        while (!(dump_valid_o && dump_idx_o == 5'd10) && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL mid_reach: got no beat idx 10 expected one within 100 cycles");
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_o, dump_valid_o, done_o, core_en_o, rf_addr_o, dump_idx_o, dump_data_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: got busy=%b valid=%b done=%b core_en=%b addr=%0d idx=%0d expected all 0",
                     busy_o, dump_valid_o, done_o, core_en_o, rf_addr_o, dump_idx_o);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        repeat (10) step();
        checks++;
        if (done_q.size() != 0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d done %0d beats expected 0 0", done_q.size(), got_q.size());
        end
        clear_log();
        pulse_start(1'b0);
        run_until(1, 200);
        checks++;
        if (got_q.size() != 31 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL mid_restart: got %0d beats first idx %0d expected 31 from 1", got_q.size(), (got_q.size() > 0) ? int'(got_q[0].idx) : -1);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 95) begin
            errors++;
            $display("FAIL mid_restart_done: got %0d expected 95", (done_q.size() > 0) ? done_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        model_dump(1, 31);
        clear_log();
        pulse_start(1'b1);
        run_until(2, 300);
        start_i = 1'b0;
        checks++;
        if (done_q.size() < 2 || done_q[0] != 95 || done_q[1] != 191) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses first %0d second %0d expected 95 191", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1);
        end
        checks++;
        if (core_en_hist[96] !== 1'b1 || core_en_hist[97] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: got core_en %b %b expected 1 0", core_en_hist[96], core_en_hist[97]);
        end
        for (int i = 0; i < 62 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i % 31]) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %0d/%0h expected %0d/%0h", i, got_q[i].idx, got_q[i].data, exp_q[i % 31].idx, exp_q[i % 31].data);
            end
        end
    endtask

    task automatic test_core_gating();
        do_reset();
        clear_log();
        en_i = 1'b0;
        #1;
        checks++;
        if (core_en_o !== 1'b0) begin
            errors++;
            $display("FAIL gate_idle_off: got %b expected 0", core_en_o);
        end
        en_i = 1'b1;
        #1;
        checks++;
        if (core_en_o !== 1'b1) begin
            errors++;
            $display("FAIL gate_idle_on: got %b expected 1", core_en_o);
        end
        en_i = 1'b0;
        pulse_start(1'b0);
        repeat (10) step();
        en_i = 1'b1;
        #1;
        checks++;
        if (core_en_o !== 1'b0) begin
            errors++;
            $display("FAIL gate_busy: got %b expected 0", core_en_o);
        end
        run_until(1, 200);
        checks++;
        if (core_en_hist[5] !== 1'b0 || core_en_o !== 1'b1) begin
            errors++;
            $display("FAIL gate_resume: got %b then %b expected 0 then 1", core_en_hist[5], core_en_o);
        end
    endtask

    task automatic test_single_register();
        int beats, done_at, ndone;
        logic [AW-1:0]   b_idx;
        logic [XLEN-1:0] b_data;
        do_reset();
        mem[4] = 32'd55;
        beats = 0;
        ndone = 0;
        done_at = -1;
        b_idx = '0;
        b_data = '0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (valid1 && ready1) begin
                beats++;
                b_idx = idx1;
                b_data = data1;
                $display("beat1 cyc=%0d idx=%0d data=%08h", c, idx1, data1);
            end
            if (done1) begin
                ndone++;
                done_at = c;
`ifdef RF_DUMP_CSUM_EN
                checks++;
                if (csum1 !== 32'd55) begin
                    errors++;
                    $display("FAIL single_csum: got %0d expected 55", csum1);
                end
`endif
            end
        end
        checks++;
        if (beats != 1 || b_idx !== 5'd4 || b_data !== 32'd55) begin
            errors++;
            $display("FAIL single_beat: got %0d beats (%0d,%0d) expected 1 (4,55)", beats, b_idx, b_data);
        end
        checks++;
        if (ndone != 1 || done_at != 5) begin
            errors++;
            $display("FAIL single_done: got %0d pulses at %0d expected 1 at 5", ndone, done_at);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        clear_log();
        test_reset();
        test_full_dump();
        test_backpressure();
        test_random_ready();
        test_start_while_busy();
        test_reset_mid_dump();
        test_back_to_back();
        test_core_gating();
        test_single_register();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
